// File: rtl/ifu_fetch_queue.sv
// Pipelined instruction fetch: owns the fetch PC, keeps up to FQ_DEPTH AXI-lite
// reads in flight and buffers returned instructions for the IDU in a FIFO.
module ifu_fetch_queue #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ADDR_W   = 32,
  parameter int unsigned     DATA_W   = 64,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_hold,
  input  logic              isIntrPC,
  input  logic              is_jump,
  input  logic [XLEN-1:0]   IntrPC,
  input  logic [XLEN-1:0]   JumpPc,
  output logic              ARVALID,
  output logic [ADDR_W-1:0] ARADDR,
  input  logic              ARREADY,
  input  logic              RVALID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  output logic              RREADY,
  output logic              ifu_valid,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              fault_o,
  input  logic              idu_ready
);

  localparam int unsigned    PTR_W    = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned    CNT_W    = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C  = (CNT_W + 1)'(FQ_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              ar_stale_q, ar_stale_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rq_head_q, rq_head_d, rq_tail_q, rq_tail_d;

  logic [XLEN-1:0]   fq_pc_q    [FQ_DEPTH];
  logic [31:0]       fq_inst_q  [FQ_DEPTH];
  logic              fq_fault_q [FQ_DEPTH];
  logic [XLEN-1:0]   rq_pc_q    [FQ_DEPTH];

  logic              ar_hs_s, r_hs_s, redirect_s, stale_hs_s, drop_ret_s;
  logic              push_s, pop_s;
  logic [XLEN-1:0]   target_raw_s, target_s, resp_pc_s;
  logic [31:0]       inst_sel_s;
  logic [CNT_W:0]    occ_s;

  assign ar_hs_s      = arvalid_q & ARREADY;
  assign r_hs_s       = RVALID & RREADY;
  assign redirect_s   = isIntrPC | is_jump;
  assign target_raw_s = isIntrPC ? IntrPC : JumpPc;
  assign target_s     = target_raw_s & ~(XLEN'(2'b11));
  assign stale_hs_s   = ar_hs_s & ar_stale_q;
  assign drop_ret_s   = r_hs_s & (drop_q != CNT_ZERO);
  assign push_s       = r_hs_s & (drop_q == CNT_ZERO) & ~redirect_s;
  assign pop_s        = (count_q != CNT_ZERO) & idu_ready;
  // Responses return in request order, so the oldest tracked request PC owns this beat.
  assign resp_pc_s    = rq_pc_q[rq_head_q];

  if (DATA_W == 64) begin : g_data64
    assign inst_sel_s = resp_pc_s[2] ? RDATA[63:32] : RDATA[31:0];
  end else begin : g_data32
    assign inst_sel_s = RDATA[31:0];
  end

  assign RREADY    = rst;
  assign ARVALID   = arvalid_q;
  assign ARADDR    = araddr_q;
  assign ifu_valid = (count_q != CNT_ZERO);
  assign inst_o    = fq_inst_q[head_q];
  assign pc_o      = fq_pc_q[head_q];
  assign fault_o   = fq_fault_q[head_q];

  // Next-state for counters, fetch PC, queue pointers and the AR channel.
  always_comb begin
    inflight_d = inflight_q;
    drop_d     = drop_q;
    ar_stale_d = ar_stale_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rq_head_d  = rq_head_q;
    rq_tail_d  = rq_tail_q;
    arvalid_d  = 1'b0;
    araddr_d   = araddr_q;
    occ_s      = {(CNT_W + 1){1'b0}};

    if (ar_hs_s && !r_hs_s) begin
      inflight_d = inflight_q + CNT_ONE;
    end else if (!ar_hs_s && r_hs_s) begin
      inflight_d = inflight_q - CNT_ONE;
    end else begin
      inflight_d = inflight_q;
    end

    if (ar_hs_s) begin
      rq_tail_d = rq_tail_q + PTR_ONE;
    end else begin
      rq_tail_d = rq_tail_q;
    end
    if (r_hs_s) begin
      rq_head_d = rq_head_q + PTR_ONE;
    end else begin
      rq_head_d = rq_head_q;
    end

    // Everything accepted but not yet returned after this cycle becomes stale on a redirect.
    if (redirect_s) begin
      drop_d = inflight_d;
    end else if (stale_hs_s && !drop_ret_s) begin
      drop_d = drop_q + CNT_ONE;
    end else if (!stale_hs_s && drop_ret_s) begin
      drop_d = drop_q - CNT_ONE;
    end else begin
      drop_d = drop_q;
    end

    if (redirect_s && arvalid_q && !ARREADY) begin
      ar_stale_d = 1'b1;
    end else if (ar_hs_s) begin
      ar_stale_d = 1'b0;
    end else begin
      ar_stale_d = ar_stale_q;
    end

    if (redirect_s) begin
      fetch_pc_d = target_s;
    end else if (ar_hs_s && !ar_stale_q) begin
      fetch_pc_d = fetch_pc_q + XLEN'(3'd4);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    if (redirect_s) begin
      head_d  = PTR_ZERO;
      tail_d  = PTR_ZERO;
      count_d = CNT_ZERO;
    end else begin
      head_d = pop_s ? (head_q + PTR_ONE) : head_q;
      tail_d = push_s ? (tail_q + PTR_ONE) : tail_q;
      if (push_s && !pop_s) begin
        count_d = count_q + CNT_ONE;
      end else if (!push_s && pop_s) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end

    // A new request is only raised if its response is guaranteed a FIFO slot.
    occ_s = {1'b0, inflight_d} + {1'b0, count_d};
    if (arvalid_q && !ARREADY) begin
      arvalid_d = 1'b1;
      araddr_d  = araddr_q;
    end else if (!fetch_hold && !ar_stale_d && (occ_s < DEPTH_C)) begin
      arvalid_d = 1'b1;
      araddr_d  = fetch_pc_d[ADDR_W-1:0];
    end else begin
      arvalid_d = 1'b0;
      araddr_d  = araddr_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      arvalid_q  <= 1'b0;
      araddr_q   <= {ADDR_W{1'b0}};
      inflight_q <= CNT_ZERO;
      drop_q     <= CNT_ZERO;
      ar_stale_q <= 1'b0;
      head_q     <= PTR_ZERO;
      tail_q     <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      rq_head_q  <= PTR_ZERO;
      rq_tail_q  <= PTR_ZERO;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fq_pc_q[i]    <= {XLEN{1'b0}};
        fq_inst_q[i]  <= 32'h0000_0000;
        fq_fault_q[i] <= 1'b0;
        rq_pc_q[i]    <= {XLEN{1'b0}};
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      ar_stale_q <= ar_stale_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rq_head_q  <= rq_head_d;
      rq_tail_q  <= rq_tail_d;
      if (push_s) begin
        fq_pc_q[tail_q]    <= resp_pc_s;
        fq_inst_q[tail_q]  <= inst_sel_s;
        fq_fault_q[tail_q] <= (RRESP != 2'b00);
      end else begin
        fq_pc_q[tail_q]    <= fq_pc_q[tail_q];
        fq_inst_q[tail_q]  <= fq_inst_q[tail_q];
        fq_fault_q[tail_q] <= fq_fault_q[tail_q];
      end
      if (ar_hs_s) begin
        rq_pc_q[rq_tail_q] <= fetch_pc_q;
      end else begin
        rq_pc_q[rq_tail_q] <= rq_pc_q[rq_tail_q];
      end
    end
  end

endmodule
